// File: rtl/cpu_pkg.sv
// Shared opcode, ALU code and sequencer state definitions for the 4-bit-opcode CPU.
// The HALT state exists only when SEQ_ILLEGAL_TRAP_EN is defined.
package cpu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_JUMP  = 4'h4;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

`ifdef SEQ_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } seq_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB
  } seq_state_t;
`endif

  typedef struct packed {
    logic       is_alu;
    logic       is_mem;
    logic       is_store;
    logic       is_jump;
    logic       is_legal;
    logic [2:0] alu_op;
  } dec_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode classifier for the sequencer; opcodes above JUMP are undefined.
module seq_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_alu,
  output logic       is_mem,
  output logic       is_store,
  output logic       is_jump,
  output logic       is_legal,
  output logic [2:0] alu_op
);

  always_comb begin
    is_alu   = (opcode == OP_ADD) || (opcode == OP_SUB);
    is_mem   = (opcode == OP_LOAD) || (opcode == OP_STORE);
    is_store = (opcode == OP_STORE);
    is_jump  = (opcode == OP_JUMP);
    is_legal = is_alu || is_mem || is_jump;
    // Loads write back the memory word through the adder path, hence ADD.
    alu_op   = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer owning the PC and IR.
// Define SEQ_ILLEGAL_TRAP_EN to trap undefined opcodes into HALT instead of treating them as NOPs.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic [INSTR_W-1:0] ir,
  output logic               reg_we,
  output logic [2:0]         alu_op,
  output logic               busy,
  output logic               illegal
);

  seq_state_t         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  dec_t               dec_q, dec_d, dec_ir;
  logic               imem_req_q, imem_req_d;
  logic               dmem_req_q, dmem_req_d;
  logic               dmem_we_q, dmem_we_d;
  logic               reg_we_q, reg_we_d;
  logic [2:0]         alu_op_q, alu_op_d;
  logic               busy_q, busy_d;
  logic               illegal_q, illegal_d;
  seq_state_t         boundary_state;

  logic       d_is_alu, d_is_mem, d_is_store, d_is_jump, d_is_legal;
  logic [2:0] d_alu_op;

  seq_decode u_decode (
    .opcode   (ir_q[INSTR_W-1 -: 4]),
    .is_alu   (d_is_alu),
    .is_mem   (d_is_mem),
    .is_store (d_is_store),
    .is_jump  (d_is_jump),
    .is_legal (d_is_legal),
    .alu_op   (d_alu_op)
  );

  always_comb begin
    dec_ir = {d_is_alu, d_is_mem, d_is_store, d_is_jump, d_is_legal, d_alu_op};
  end

  always_comb begin
    boundary_state = stop ? ST_IDLE : ST_FETCH;
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    dec_d     = dec_q;
    illegal_d = illegal_q | ((state_q == ST_EXEC) & ~dec_q.is_legal);

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        dec_d   = dec_ir;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_q.is_alu) begin
          state_d = ST_WB;
        end else if (dec_q.is_mem) begin
          state_d = ST_MEM;
        end else if (dec_q.is_jump) begin
          pc_d    = ir_q[PC_W-1:0];
          state_d = boundary_state;
        end else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
          state_d = ST_HALT;
`else
          state_d = boundary_state;
`endif
        end
      end
      ST_MEM: begin
        if (dmem_ack) state_d = dec_q.is_store ? boundary_state : ST_WB;
      end
      ST_WB: begin
        state_d = boundary_state;
      end
`ifdef SEQ_ILLEGAL_TRAP_EN
      ST_HALT: begin
        state_d = ST_HALT;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    imem_req_d = (state_d == ST_FETCH);
    dmem_req_d = (state_d == ST_MEM);
    dmem_we_d  = (state_d == ST_MEM) && dec_d.is_store;
    reg_we_d   = (state_d == ST_WB);
    alu_op_d   = ((state_d == ST_EXEC) || (state_d == ST_WB)) ? dec_d.alu_op : ALU_ADD;
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      dec_q      <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      alu_op_q   <= ALU_ADD;
      busy_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      dec_q      <= dec_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      reg_we_q   <= reg_we_d;
      alu_op_q   <= alu_op_d;
      busy_q     <= busy_d;
      illegal_q  <= illegal_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign ir        = ir_q;
  assign reg_we    = reg_we_q;
  assign alu_op    = alu_op_q;
  assign busy      = busy_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed cases plus random instruction stream
// checked cycle by cycle against a per-instruction timeline model.
module tb_cpu_sequencer;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               imem_ack = 1'b0;
  logic               dmem_ack = 1'b0;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               imem_req, dmem_req, dmem_we, reg_we, busy, illegal;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] ir;
  logic [2:0]         alu_op;

  int vectors = 0;
  int miscompares = 0;
  int unsigned model_pc = 0;
  bit model_ill = 1'b0;

  typedef struct {
    bit       ireq;
    bit       dreq;
    bit       dwe;
    bit       rwe;
    bit [2:0] alu;
    bit       iack;
    bit       dack;
    bit       ir_ok;
  } cyc_t;

  cyc_t tl[$];

  cpu_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .ir         (ir),
    .reg_we     (reg_we),
    .alu_op     (alu_op),
    .busy       (busy),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected cycle-by-cycle shape of one instruction, starting at its first FETCH cycle.
  task automatic build_timeline(input int op, input int iwait, input int dwait);
    cyc_t c;
    tl.delete();
    for (int i = 0; i <= iwait; i++) begin
      c = '{default: 0};
      c.ireq = 1'b1;
      c.iack = (i == iwait);
      tl.push_back(c);
    end
    c = '{default: 0};
    c.ir_ok = 1'b1;
    tl.push_back(c);
    c.alu = (op == 1) ? 3'd1 : 3'd0;
    tl.push_back(c);
    if (op == 2 || op == 3) begin
      for (int i = 0; i <= dwait; i++) begin
        c = '{default: 0};
        c.ir_ok = 1'b1;
        c.dreq  = 1'b1;
        c.dwe   = (op == 3);
        c.dack  = (i == dwait);
        tl.push_back(c);
      end
    end
    if (op <= 2) begin
      c = '{default: 0};
      c.ir_ok = 1'b1;
      c.rwe   = 1'b1;
      c.alu   = (op == 1) ? 3'd1 : 3'd0;
      tl.push_back(c);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_instr(input logic [15:0] instr, input int iwait, input int dwait,
                           input bit stop_req);
    int op;
    int last;
    op = int'(instr[15:12]);
    build_timeline(op, iwait, dwait);
    last = tl.size() - 1;
    for (int k = 0; k <= last; k++) begin
      chk("busy", busy, 1);
      chk("imem_req", imem_req, tl[k].ireq);
      if (tl[k].ireq) chk("imem_addr", imem_addr, model_pc);
      chk("dmem_req", dmem_req, tl[k].dreq);
      if (tl[k].dreq) chk("dmem_we", dmem_we, tl[k].dwe);
      chk("reg_we", reg_we, tl[k].rwe);
      chk("alu_op", alu_op, tl[k].alu);
      chk("illegal", illegal, model_ill);
      if (tl[k].ir_ok) chk("ir", ir, instr);
      imem_ack   = tl[k].ireq ? tl[k].iack : 1'($urandom % 2);
      imem_rdata = tl[k].iack ? instr : 16'($urandom);
      dmem_ack   = tl[k].dreq ? tl[k].dack : 1'($urandom % 2);
      start      = 1'($urandom % 2);
      stop       = stop_req ? 1'b1 : ((k == last) ? 1'b0 : 1'($urandom % 2));
      @(negedge clk);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    model_ill = model_ill | (op > 4);
    model_pc  = (op == 4) ? int'(instr[7:0]) : (model_pc + 1) % 256;
    chk("ir_hold", ir, instr);
`ifdef SEQ_ILLEGAL_TRAP_EN
    if (op > 4) begin
      for (int h = 0; h < 3; h++) begin
        chk("halt_busy", busy, 1);
        chk("halt_imem_req", imem_req, 0);
        chk("halt_dmem_req", dmem_req, 0);
        chk("halt_reg_we", reg_we, 0);
        chk("halt_illegal", illegal, 1);
        start = 1'b1;
        @(negedge clk);
      end
      start = 1'b0;
      return;
    end
`endif
    if (stop_req) begin
      chk("stop_busy", busy, 0);
      chk("stop_imem_req", imem_req, 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_pc  = 0;
    model_ill = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] instr;
    int          r;
    bit          s;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_ir", ir, 0);
    chk("rst_pc", imem_addr, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_start", busy, 0);

    do_start();
    run_instr(16'h0ABC, 0, 0, 1'b0);   // add, zero wait, pc 0 -> 1
    run_instr(16'h4005, 1, 0, 1'b0);   // jump to 5
    run_instr(16'h2123, 0, 3, 1'b0);   // load at 5, dmem ack after 3 waits
    run_instr(16'h4012, 0, 0, 1'b0);   // jump to 0x12
    run_instr(16'h40FF, 2, 0, 1'b0);   // jump to 0xFF
    run_instr(16'h4012, 0, 0, 1'b0);   // jump at 0xFF: target beats wrap
    run_instr(16'h40FF, 0, 0, 1'b0);
    run_instr(16'h0001, 0, 0, 1'b0);   // add at 0xFF wraps pc to 0
    run_instr(16'h1234, 0, 0, 1'b0);   // sub
    run_instr(16'h3456, 1, 2, 1'b1);   // store with stop held, ends idle
    repeat (2) @(negedge clk);
    chk("idle_after_stop", busy, 0);

    do_start();
`ifdef SEQ_ILLEGAL_TRAP_EN
    run_instr(16'hF000, 0, 0, 1'b0);
    do_reset();
    do_start();
`else
    run_instr(16'hF000, 0, 0, 1'b0);
    run_instr(16'h0000, 0, 0, 1'b0);   // illegal stays set while executing on
`endif

    // Random instruction stream.
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom % 6);
`ifdef SEQ_ILLEGAL_TRAP_EN
      if (r == 5) r = int'($urandom % 5);
`else
      if (r == 5) r = 5 + int'($urandom % 11);
`endif
      instr = {4'(r), 12'($urandom)};
      s = ($urandom % 8) == 0;
      run_instr(instr, int'($urandom % 4), int'($urandom % 4), s);
      if (s) begin
        repeat (int'($urandom % 3)) @(negedge clk);
        do_start();
      end
    end

    // Reset while a fetch is outstanding.
    chk("pre_rst_imem_req", imem_req, 1);
    imem_ack = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("async_imem_req", imem_req, 0);
    chk("async_busy", busy, 0);
    chk("async_pc", imem_addr, 0);
    chk("async_ir", ir, 0);
    @(negedge clk);
    imem_ack  = 1'b0;
    rst_n     = 1'b1;
    model_pc  = 0;
    model_ill = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_illegal", illegal, 0);
    do_start();
    run_instr(16'h0000, 0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
